// File: rtl/uart_stopwatch_lap_core_if.sv
// UART FIFO-side signal bundle for the stopwatch core.
// The master modport belongs to the core; the slave modport belongs to the FIFO/UART side.
interface uart_stopwatch_lap_core_if;
    logic       rx_empty;
    logic [7:0] rd_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] wr_data;

    modport master (
        input  rx_empty,
        input  rd_data,
        input  tx_full,
        output rd_uart,
        output wr_uart,
        output wr_data
    );

    modport slave (
        output rx_empty,
        output rd_data,
        output tx_full,
        input  rd_uart,
        input  wr_uart,
        input  wr_data
    );
endinterface

// File: rtl/uart_stopwatch_lap_core.sv
// BCD stopwatch with lap capture, driven by single-byte ASCII commands from a UART receive FIFO.
// 'R'/'Q' send the count or lap value back as decimal digits followed by CR LF.
module uart_stopwatch_lap_core #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    uart_stopwatch_lap_core_if.master uart,
    output logic [4*DIGITS-1:0]      o_count,
    output logic [4*DIGITS-1:0]      o_lap,
    output logic                     o_run,
    output logic                     o_up,
    output logic                     o_busy
);

    localparam int unsigned CW   = 4 * DIGITS;
    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
    localparam logic [IdxW-1:0] IdxTop = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StDigit, StCr, StLf} tx_state_e;

    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   lap_q, lap_d;
    logic [CW-1:0]   snap_q, snap_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic            run_q, run_d;
    logic            up_q, up_d;
    tx_state_e       state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;

    logic       cmd_valid;
    logic [7:0] cmd;
    logic       tick;
    logic [3:0] digit_sel;
    logic       wr;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Every byte is popped as soon as it appears; bytes seen during reset are simply not decoded.
    assign uart.rd_uart = ~uart.rx_empty;
    assign cmd_valid    = ~uart.rx_empty & ~i_reset;
    assign cmd = (uart.rd_data >= 8'h61 && uart.rd_data <= 8'h7A) ? (uart.rd_data & 8'hDF)
                                                                    : uart.rd_data;
    assign tick = run_q && (presc_q == PreMax);

    always_comb begin
        digit_sel = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                digit_sel = snap_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        lap_d   = lap_q;
        presc_d = presc_q;
        run_d   = run_q;
        up_d    = up_q;

        if (cmd_valid && cmd == "G") run_d = 1'b1;
        if (cmd_valid && cmd == "P") run_d = 1'b0;
        if (cmd_valid && cmd == "U") up_d = ~up_q;
        // Lap takes the value visible this cycle, i.e. before any tick lands.
        if (cmd_valid && cmd == "L") lap_d = count_q;

        if (cmd_valid && cmd == "C") begin
            count_d = '0;
            presc_d = '0;
        end else if (tick) begin
            count_d = up_q ? bcd_inc(count_q) : bcd_dec(count_q);
            presc_d = '0;
        end else if (run_q) begin
            presc_d = presc_q + PreW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        wr      = 1'b0;
        uart.wr_data = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && (cmd == "R" || cmd == "Q")) begin
                    snap_d  = (cmd == "R") ? count_q : lap_q;
                    idx_d   = IdxTop;
                    state_d = StDigit;
                end
            end
            StDigit: begin
                uart.wr_data = {4'h3, digit_sel};
                if (!uart.tx_full) begin
                    wr = 1'b1;
                    if (idx_q == '0) begin
                        state_d = StCr;
                    end else begin
                        idx_d = idx_q - IdxW'(1);
                    end
                end
            end
            StCr: begin
                uart.wr_data = 8'h0D;
                if (!uart.tx_full) begin
                    wr      = 1'b1;
                    state_d = StLf;
                end
            end
            StLf: begin
                uart.wr_data = 8'h0A;
                if (!uart.tx_full) begin
                    wr      = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Reset aborts an in-flight frame in the very cycle it is asserted.
    assign uart.wr_uart = wr & ~i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
            lap_q   <= '0;
            snap_q  <= '0;
            presc_q <= '0;
            run_q   <= 1'b0;
            up_q    <= 1'b1;
            state_q <= StIdle;
            idx_q   <= IdxTop;
        end else begin
            count_q <= count_d;
            lap_q   <= lap_d;
            snap_q  <= snap_d;
            presc_q <= presc_d;
            run_q   <= run_d;
            up_q    <= up_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign o_count = count_q;
    assign o_lap   = lap_q;
    assign o_run   = run_q;
    assign o_up    = up_q;
    assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_stopwatch_lap_core.sv
// Randomised scoreboard bench: a 4-digit and an 8-digit core share one command stream and are
// compared against an integer-arithmetic model of the stopwatch and report framing.
module tb_uart_stopwatch_lap_core;

    localparam int TickDiv = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_stopwatch_lap_core_if u4 ();
    uart_stopwatch_lap_core_if u8 ();

    logic [15:0] count4, lap4;
    logic [31:0] count8, lap8;
    logic        run4, up4, busy4, run8, up8, busy8;

    uart_stopwatch_lap_core #(.DIGITS(4), .TICK_DIV(TickDiv)) u_dut4 (
        .i_clk   (clk),
        .i_reset (rst),
        .uart    (u4),
        .o_count (count4),
        .o_lap   (lap4),
        .o_run   (run4),
        .o_up    (up4),
        .o_busy  (busy4)
    );

    uart_stopwatch_lap_core #(.DIGITS(8), .TICK_DIV(TickDiv)) u_dut8 (
        .i_clk   (clk),
        .i_reset (rst),
        .uart    (u8),
        .o_count (count8),
        .o_lap   (lap8),
        .o_run   (run8),
        .o_up    (up8),
        .o_busy  (busy8)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    int dg[2] = '{4, 8};
    int m_count[2], m_lap[2], m_presc[2], m_rem[2];
    bit m_run[2], m_up[2];
    bit monitor_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic push_exp(input int d, input logic [7:0] b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    task automatic model_step(input int d, input bit r, input bit rxv, input logic [7:0] b,
                              input bit full);
        int         modulus, old, val, p;
        bit         busy_now, tick;
        logic [7:0] c;
        if (r) begin
            m_count[d] = 0; m_lap[d] = 0; m_presc[d] = 0; m_rem[d] = 0;
            m_run[d] = 1'b0; m_up[d] = 1'b1;
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
            return;
        end
        modulus = 1;
        for (int i = 0; i < dg[d]; i++) modulus = modulus * 10;
        busy_now = (m_rem[d] > 0);
        if (busy_now && !full) m_rem[d]--;
        tick = m_run[d] && (m_presc[d] == TickDiv - 1);
        c = rxv ? b : 8'h00;
        if (c >= "a" && c <= "z") c = c - 8'd32;
        old = m_count[d];
        if ((c == "R" || c == "Q") && !busy_now) begin
            val = (c == "R") ? old : m_lap[d];
            p = modulus / 10;
            for (int i = 0; i < dg[d]; i++) begin
                push_exp(d, 8'(48 + (val / p) % 10));
                p = p / 10;
            end
            push_exp(d, 8'h0D);
            push_exp(d, 8'h0A);
            m_rem[d] = dg[d] + 2;
        end
        if (c == "L") m_lap[d] = old;
        if (c == "C") begin
            m_count[d] = 0;
            m_presc[d] = 0;
        end else if (tick) begin
            m_count[d] = m_up[d] ? (old + 1) % modulus : (old + modulus - 1) % modulus;
            m_presc[d] = 0;
        end else if (m_run[d]) begin
            m_presc[d]++;
        end
        if (c == "G") m_run[d] = 1'b1;
        if (c == "P") m_run[d] = 1'b0;
        if (c == "U") m_up[d] = !m_up[d];
    endtask

    // One clock cycle: drive inputs, check registered outputs against the model, advance model.
    task automatic step(input bit r, input bit rxv, input logic [7:0] b, input bit full);
        rst = r;
        u4.rx_empty = ~rxv; u8.rx_empty = ~rxv;
        u4.rd_data  = b;    u8.rd_data  = b;
        u4.tx_full  = full; u8.tx_full  = full;
        #2;
        check("count4", 32'(count4), to_bcd(m_count[0], 4));
        check("lap4",   32'(lap4),   to_bcd(m_lap[0], 4));
        check("run4",   32'(run4),   32'(m_run[0]));
        check("up4",    32'(up4),    32'(m_up[0]));
        check("busy4",  32'(busy4),  32'(m_rem[0] > 0));
        check("count8", count8,      to_bcd(m_count[1], 8));
        check("lap8",   lap8,        to_bcd(m_lap[1], 8));
        check("run8",   32'(run8),   32'(m_run[1]));
        check("up8",    32'(up8),    32'(m_up[1]));
        check("busy8",  32'(busy8),  32'(m_rem[1] > 0));
        check("rd_uart", 32'(u4.rd_uart), 32'(rxv));
        model_step(0, r, rxv, b, full);
        model_step(1, r, rxv, b, full);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic cmd(input logic [7:0] b);
        step(1'b0, 1'b1, b, 1'b0);
    endtask

    // Stops right before a cycle in which the model expects a tick (optionally at a given count).
    task automatic run_until_tick(input int target);
        int n;
        n = 0;
        while (!(m_run[0] && m_presc[0] == TickDiv - 1 && (target < 0 || m_count[0] == target))
               && n < 1000) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            failures++;
            $display("FAIL tick_wait_timeout actual=%0d required=<1000", n);
        end
    endtask

    task automatic mon(input int d, input logic full, input logic wr, input logic [7:0] data);
        logic [7:0] e;
        if (full) check($sformatf("no_push_while_full%0d", d), 32'(wr), 32'd0);
        if (wr) begin
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                checks++;
                failures++;
                $display("FAIL unexpected_push%0d actual=%h required=none", d, data);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check($sformatf("tx_byte%0d", d), 32'(data), 32'(e));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (monitor_on) begin
                mon(0, u4.tx_full, u4.wr_uart, u4.wr_data);
                mon(1, u8.tx_full, u8.wr_uart, u8.wr_data);
            end
        end
    end

    string alph = "GPCULRQgpculrqXz5 ";

    initial begin
        rst = 1'b1;
        u4.rx_empty = 1'b1; u8.rx_empty = 1'b1;
        u4.rd_data  = 8'h00; u8.rd_data = 8'h00;
        u4.tx_full  = 1'b0; u8.tx_full  = 1'b0;
        model_step(0, 1'b1, 1'b0, 8'h00, 1'b0);
        model_step(1, 1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        monitor_on = 1'b1;
        // Byte offered during reset must be ignored.
        step(1'b1, 1'b1, "G", 1'b0);
        idle(2);

        // Run 40 cycles then report: "0010" / "00000010".
        cmd("G");
        idle(40);
        cmd("R");
        idle(8);

        // Lap on the tick that takes 41 -> 42, then report the lap.
        cmd("C");
        run_until_tick(41);
        cmd("L");
        check("lap_on_tick", 32'(lap4), 32'h0041);
        check("count_after_lap_tick", 32'(count4), 32'h0042);
        cmd("q");
        idle(8);

        // Back-pressure for 5 cycles after two bytes of a frame.
        cmd("R");
        idle(2);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(8);

        // Second 'R' while busy is dropped.
        cmd("R");
        idle(1);
        cmd("R");
        idle(10);

        // Clear on a tick cycle.
        run_until_tick(-1);
        cmd("c");
        check("clear_beats_tick", 32'(count4), 32'h0000);

        // Wrap both ways: down from 0000 then up from 9999.
        cmd("P");
        cmd("C");
        cmd("U");
        cmd("G");
        run_until_tick(-1);
        idle(1);
        check("down_wrap", 32'(count4), 32'h9999);
        check("down_wrap8", count8, 32'h99999999);
        cmd("u");
        run_until_tick(-1);
        idle(1);
        check("up_wrap", 32'(count4), 32'h0000);

        // Reset after the second byte of a frame.
        cmd("R");
        idle(2);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(8);

        // Randomised traffic with occasional back-pressure and resets.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 999) < 3,
                 $urandom_range(0, 99) < 15,
                 8'(alph[$urandom_range(0, alph.len() - 1)]),
                 $urandom_range(0, 99) < 20);
        end

        idle(30);
        check("drain4", 32'(exp_q0.size()), 32'd0);
        check("drain8", 32'(exp_q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_stopwatch_lap_core.md
UART_STOPWATCH_LAP_CORE -- requirements
Module: uart_stopwatch_lap_core

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, number of BCD digits in the stopwatch (legal range 2..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 10_000_000, i_clk cycles per count increment (0.1 s at 100 MHz; legal minimum 2).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_rx_empty  input  1  receive FIFO empty flag.
REQ-006 i_rd_data  input  8  receive FIFO head byte, first-word-fall-through, valid whenever i_rx_empty=0.
REQ-007 o_rd_uart  output  1  receive FIFO pop strobe.
REQ-008 i_tx_full  input  1  transmit FIFO full flag.
REQ-009 o_wr_uart  output  1  transmit FIFO push strobe.
REQ-010 o_wr_data  output  8  transmit byte, valid when o_wr_uart=1.
REQ-011 o_count  output  4*DIGITS  live BCD count, digit 0 in bits [3:0].
REQ-012 o_lap  output  4*DIGITS  captured lap value, same packing.
REQ-013 o_run, o_up, o_busy  output  1 each  running flag, count-direction flag (1=up), report-in-progress flag.

Function
REQ-014 o_rd_uart SHALL equal ~i_rx_empty combinationally; every available byte is consumed one per cycle and decoded in that same cycle.
REQ-015 Command decode, case-insensitive ASCII: 'G' run=1; 'P' run=0; 'C' count=0 and prescaler=0; 'U' toggle up; 'L' lap<=count; 'R' report count; 'Q' report lap; all other bytes ignored with no side effect.
REQ-016 Prescaler SHALL advance only while run=1, hold while run=0, and issue one tick on the cycle it reaches TICK_DIV-1, then return to 0.
REQ-017 On tick with up=1, count SHALL increment in BCD with per-digit carry; all-9s wraps to all-0s.
REQ-018 On tick with up=0, count SHALL decrement in BCD with per-digit borrow; all-0s wraps to all-9s.
REQ-019 'C' and a tick in the same cycle: clear wins, count=0.
REQ-020 'L' and a tick in the same cycle: lap captures the pre-tick count.
REQ-021 'R'/'Q' SHALL snapshot the selected value into a report register on the decode cycle; the running count continues unaffected.
REQ-022 Transmit FSM states: IDLE, DIGIT, CR, LF. IDLE->DIGIT on accepted 'R'/'Q', digit index=DIGITS-1.
REQ-023 In DIGIT, each cycle with i_tx_full=0 SHALL push ASCII '0'+snapshot digit[index] (most significant first) and decrement index; after index 0 go to CR.
REQ-024 CR pushes 8'h0D, LF pushes 8'h0A, each only when i_tx_full=0; LF->IDLE after push.
REQ-025 o_wr_uart SHALL never assert while i_tx_full=1; the FSM stalls in place with o_wr_data held.
REQ-026 A report is DIGITS+2 bytes; with no back-pressure latency from decode cycle to first push is 1 cycle, frame occupies DIGITS+2 consecutive cycles.
REQ-027 'R'/'Q' received while o_busy=1 SHALL be dropped; no queueing, in-flight frame unaffected.
REQ-028 o_busy=1 in every state except IDLE.
REQ-029 o_count, o_lap, o_run, o_up SHALL be registered; o_wr_uart and o_wr_data SHALL be decoded from FSM state and i_tx_full.

Reset
REQ-030 On i_reset=1 at a clock edge: count=0, lap=0, prescaler=0, run=0, up=1, FSM=IDLE, index=DIGITS-1, snapshot=0.
REQ-031 During reset o_wr_uart=0 and o_rd_uart=~i_rx_empty, but bytes popped during reset SHALL be discarded.
REQ-032 Reset mid-report SHALL abort the frame immediately; no further bytes pushed.

Verification
REQ-033 DIGITS=4, TICK_DIV=4: send 'G', run 40 cycles, send 'R' -> tx bytes "0010",0x0D,0x0A; o_busy high exactly 6 cycles.
REQ-034 DIGITS=4, preload via 9999 ticks up -> next tick gives o_count=0000; then 'U' and one tick -> 9999.
REQ-035 Send 'L' on the tick cycle with count 0041 -> o_lap=0041, o_count=0042; 'Q' -> "0041"CRLF.
REQ-036 Hold i_tx_full=1 for 5 cycles mid-report -> no o_wr_uart during stall, frame bytes unchanged and in order after release.
REQ-037 'R' then 'R' two cycles later -> exactly one 6-byte frame; 'C' on tick cycle -> o_count=0000.
REQ-038 Assert i_reset after 2nd byte of a report -> no further pushes, all outputs at reset values next cycle; DIGITS=8 rerun of REQ-033 yields "00000010"CRLF.
